vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator, the successor to the team's fixed 256×480 sync generator. It produces horizontal and vertical counters, programmable-polarity sync pulses, blanking flags and line/frame strobes. Counters advance on a pixel clock-enable, so the block runs from the system clock. A run/stop FSM starts and halts scanning only on frame boundaries. It sits between the clock-enable generator and the pixel/colour pipeline of the video card.

---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_axis_counter.sv | 61 ++++++
 rtl/vga_timing_gen.sv | 174 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared definitions for the VGA raster timing generator:
//            default 256x480 timing set, run/stop state type and helpers
//            that derive the total line/frame lengths.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Default timing set (256 visible pixels, 480 visible lines)
  localparam int C_H_VISIBLE = 256;
  localparam int C_H_FP      = 6;
  localparam int C_H_SYNC    = 38;
  localparam int C_H_BP      = 19;
  localparam int C_V_VISIBLE = 480;
  localparam int C_V_FP      = 10;
  localparam int C_V_SYNC    = 2;
  localparam int C_V_BP      = 33;

  // Run/stop state of the scanner
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vga_state_t;

  // Pixels per line including porches and sync
  function automatic int h_total(input int visible, input int fp,
                                 input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

  // Lines per frame including porches and sync
  function automatic int v_total(input int visible, input int fp,
                                 input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_counter
// Purpose  : Modulo-TOTAL position counter for one raster axis. Exposes the
//            registered count, the value it will take after this clock, a
//            carry when it wraps, and visible/sync-window decodes of the
//            next value so the parent can register outputs that line up
//            with the count.
// Revision : 1.0 - initial release
// ============================================================================
module vga_axis_counter #(
  parameter int W          = 9,
  parameter int TOTAL      = 319,
  parameter int VISIBLE    = 256,
  parameter int SYNC_START = 262,
  parameter int SYNC_LEN   = 38
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         advance,
  output logic [W-1:0] count,
  output logic [W-1:0] next_count,
  output logic         carry,
  output logic         next_visible,
  output logic         next_in_sync
);

  localparam logic [W-1:0] C_LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] C_VISIBLE    = W'(VISIBLE);
  localparam logic [W-1:0] C_SYNC_FIRST = W'(SYNC_START);
  localparam logic [W-1:0] C_SYNC_LAST  = W'(SYNC_START + SYNC_LEN - 1);

  logic [W-1:0] r_count;
  logic         w_at_last;

  assign w_at_last = (r_count == C_LAST);

  // Next position: wrap to zero after the last position, hold when idle
  always_comb begin
    next_count = r_count;
    if (advance) begin
      next_count = w_at_last ? '0 : r_count + 1'b1;
    end
  end

  assign carry        = advance && w_at_last;
  assign next_visible = (next_count < C_VISIBLE);
  assign next_in_sync = (next_count >= C_SYNC_FIRST) && (next_count <= C_SYNC_LAST);
  assign count        = r_count;

  // Position register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= next_count;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VGA raster timing generator. Horizontal/vertical
//            counters advance on pix_ce; a run/stop FSM only starts or halts
//            scanning on frame boundaries. Sync, blanking and strobe outputs
//            are registered from next-state counter decodes so they always
//            describe the pixel_x/pixel_y presented in the same cycle.
//            Optional feature macro: VGA_FRAME_CNT_EN adds the frame_cnt
//            port counting completed frames (modulo 2^FCW).
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = C_H_VISIBLE,
  parameter int H_FP      = C_H_FP,
  parameter int H_SYNC    = C_H_SYNC,
  parameter int H_BP      = C_H_BP,
  parameter int V_VISIBLE = C_V_VISIBLE,
  parameter int V_FP      = C_V_FP,
  parameter int V_SYNC    = C_V_SYNC,
  parameter int V_BP      = C_V_BP,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int XW        = 9,
  parameter int YW        = 10,
  parameter int FCW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_ce,
  input  logic          enable,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FCW-1:0] frame_cnt
`endif
);

  localparam int C_H_TOTAL = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int C_V_TOTAL = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  // Reject configurations whose counters could not reach their last position
  if (C_H_TOTAL > (1 << XW)) begin : g_h_range_err
    $error("vga_timing_gen: H total %0d does not fit in XW=%0d bits", C_H_TOTAL, XW);
  end
  if (C_V_TOTAL > (1 << YW)) begin : g_v_range_err
    $error("vga_timing_gen: V total %0d does not fit in YW=%0d bits", C_V_TOTAL, YW);
  end
  if (FCW < 1) begin : g_fcw_err
    $error("vga_timing_gen: FCW must be at least 1");
  end

  vga_state_t    r_state;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_video_on;
  logic          r_line_start;
  logic          r_frame_start;

  logic          w_run;
  logic          w_advance;
  logic          w_start;
  logic          w_stop;
  logic          w_next_run;
  logic [XW-1:0] w_x;
  logic [XW-1:0] w_next_x;
  logic          w_h_carry;
  logic          w_h_visible;
  logic          w_h_sync;
  logic [YW-1:0] w_y;
  logic [YW-1:0] w_next_y;
  logic          w_frame_wrap;
  logic          w_v_visible;
  logic          w_v_sync;

  assign w_run      = (r_state == ST_RUN);
  assign w_advance  = w_run && pix_ce;
  assign w_start    = (r_state == ST_IDLE) && enable && pix_ce;
  // enable is only sampled at the frame wrap, so a mid-frame drop never truncates
  assign w_stop     = w_frame_wrap && !enable;
  assign w_next_run = w_start || (w_run && !w_stop);

  vga_axis_counter #(
    .W          (XW),
    .TOTAL      (C_H_TOTAL),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FP),
    .SYNC_LEN   (H_SYNC)
  ) u_h_cnt (
    .clk          (clk),
    .reset        (reset),
    .advance      (w_advance),
    .count        (w_x),
    .next_count   (w_next_x),
    .carry        (w_h_carry),
    .next_visible (w_h_visible),
    .next_in_sync (w_h_sync)
  );

  vga_axis_counter #(
    .W          (YW),
    .TOTAL      (C_V_TOTAL),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FP),
    .SYNC_LEN   (V_SYNC)
  ) u_v_cnt (
    .clk          (clk),
    .reset        (reset),
    .advance      (w_h_carry),
    .count        (w_y),
    .next_count   (w_next_y),
    .carry        (w_frame_wrap),
    .next_visible (w_v_visible),
    .next_in_sync (w_v_sync)
  );

  // Run/stop FSM and registered outputs decoded from the next counter values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (pix_ce) begin
        r_state       <= w_next_run ? ST_RUN : ST_IDLE;
        r_hsync       <= (w_next_run && w_h_sync) ? HS_POL : ~HS_POL;
        r_vsync       <= (w_next_run && w_v_sync) ? VS_POL : ~VS_POL;
        r_video_on    <= w_next_run && w_h_visible && w_v_visible;
        r_line_start  <= w_next_run && (w_next_x == '0);
        r_frame_start <= w_next_run && (w_next_x == '0) && (w_next_y == '0);
      end
    end
  end

  assign pixel_x     = w_x;
  assign pixel_y     = w_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign running     = w_run;

`ifdef VGA_FRAME_CNT_EN
  logic [FCW-1:0] r_frame_cnt;

  // Completed-frame counter; survives IDLE, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= '0;
    end else if (w_frame_wrap) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench for vga_timing_gen using a small raster
//            (15 x 10 positions) so full frames fit in a short run. Two
//            instances share stimulus: one with active-low syncs, one with
//            active-high syncs. A position-index model predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int HV = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VV = 6, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HV + HFP + HS + HBP;  // 15
  localparam int VT = VV + VFP + VS + VBP;  // 10
  localparam int FT = HT * VT;              // 150
  localparam int XW = 4, YW = 4, FCW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pix_ce = 1'b0;
  logic enable = 1'b0;

  logic [XW-1:0] x0, x1;
  logic [YW-1:0] y0, y1;
  logic hs0, vs0, vo0, ls0, fs0, run0;
  logic hs1, vs1, vo1, ls1, fs1, run1;
  logic [FCW-1:0] fc0, fc1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .XW(XW), .YW(YW), .FCW(FCW)
  ) dut0 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .enable(enable),
    .pixel_x(x0), .pixel_y(y0), .hsync(hs0), .vsync(vs0),
    .video_on(vo0), .line_start(ls0), .frame_start(fs0), .running(run0)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc0)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .XW(XW), .YW(YW), .FCW(FCW)
  ) dut1 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .enable(enable),
    .pixel_x(x1), .pixel_y(y1), .hsync(hs1), .vsync(vs1),
    .video_on(vo1), .line_start(ls1), .frame_start(fs1), .running(run1)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );

`ifndef VGA_FRAME_CNT_EN
  assign fc0 = '0;
  assign fc1 = '0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: linear position index within the frame, plus run flag and strobes
  typedef struct packed {
    bit run;
    int pos;
    bit ls;
    bit fs;
    int fc;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t step(input mstate_t s, input bit en, input bit ce);
    mstate_t n = s;
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (ce) begin
      if (!s.run) begin
        if (en) begin
          n.run = 1'b1; n.pos = 0; n.ls = 1'b1; n.fs = 1'b1;
        end
      end else begin
        n.pos = s.pos + 1;
        if (n.pos == FT) begin
          n.pos = 0;
          n.fc  = (s.fc + 1) % (1 << FCW);
          n.run = en;
        end
        n.ls = n.run && (n.pos % HT == 0);
        n.fs = n.run && (n.pos == 0);
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= '0;
    else        m <= step(m, enable, pix_ce);
  end

  task automatic check_dut(input string tag, input bit pol,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic hs, input logic vs, input logic vo,
                           input logic ls, input logic fs, input logic run,
                           input logic [31:0] fc);
    int ex, ey;
    bit hwin, vwin;
    ex = m.pos % HT;
    ey = m.pos / HT;
    hwin = m.run && (ex >= HV + HFP) && (ex < HV + HFP + HS);
    vwin = m.run && (ey >= VV + VFP) && (ey < VV + VFP + VS);
    chk({tag, ".x"}, x, ex);
    chk({tag, ".y"}, y, ey);
    chk({tag, ".hsync"}, hs, hwin ? pol : !pol);
    chk({tag, ".vsync"}, vs, vwin ? pol : !pol);
    chk({tag, ".video_on"}, vo, m.run && ex < HV && ey < VV);
    chk({tag, ".line_start"}, ls, m.ls);
    chk({tag, ".frame_start"}, fs, m.fs);
    chk({tag, ".running"}, run, m.run);
`ifdef VGA_FRAME_CNT_EN
    chk({tag, ".frame_cnt"}, fc, m.fc);
`else
    if (fc != 0) chk({tag, ".frame_cnt_tie"}, fc, 0);
`endif
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check_dut("dut0", 1'b0, x0, y0, hs0, vs0, vo0, ls0, fs0, run0, fc0);
    check_dut("dut1", 1'b1, x1, y1, hs1, vs1, vo1, ls1, fs1, run1, fc1);
  end

  task automatic wait_fs(input int budget, output int when);
    when = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fs0) begin
        when = cyc;
        return;
      end
    end
    chk("wait_frame_start_timeout", 0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, lows, vlows, vis, lcount, fcount, wide, px, py, fc_before;
    bit prev_fs, prev_ls;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_x", x0, 0);
    chk("rst_y", y0, 0);
    chk("rst_hsync_lo_pol", hs0, 1);
    chk("rst_hsync_hi_pol", hs1, 0);
    chk("rst_vsync_hi_pol", vs1, 0);
    chk("rst_running", run0, 0);

    // Released but not enabled: stays idle
    reset = 1'b1; pix_ce = 1'b1; enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_running", run0, 0);
    chk("idle_frame_start", fs0, 0);

    // First enable && pix_ce: enters RUN at (0,0) with both strobes
    enable = 1'b1;
    @(negedge clk);
    chk("start_running", run0, 1);
    chk("start_frame_start", fs0, 1);
    chk("start_line_start", ls0, 1);
    chk("start_x", x0, 0);
    chk("start_video_on", vo0, 1);
    @(negedge clk);
    chk("second_x", x0, 1);
    chk("second_line_start", ls0, 0);

    // One full line: hsync low for exactly HS pixels, line period HT
    while (!ls0) @(negedge clk);
    lows = 0; lcount = 0;
    for (int i = 0; i < HT - 1; i++) begin
      @(negedge clk);
      if (!hs0) lows++;
      if (ls0) lcount++;
    end
    @(negedge clk);
    if (!hs0) lows++;
    chk("hsync_low_pixels", lows, HS);
    chk("line_start_inside_line", lcount, 0);
    chk("line_period_end", ls0, 1);

    // One full frame: vsync lines, visible area size, frame period FT
    wait_fs(2 * FT, t1);
    vlows = 0; vis = 0; fcount = 0;
    for (int i = 0; i < FT; i++) begin
      if (!vs0) vlows++;
      if (vo0) vis++;
      @(negedge clk);
      if (fs0 && i < FT - 1) fcount++;
    end
    chk("vsync_low_clks", vlows, VS * HT);
    chk("visible_pixels", vis, HV * VV);
    chk("frame_start_inside_frame", fcount, 0);
    chk("frame_period_end", fs0, 1);

    // pix_ce every 3rd clock: frame period triples, strobes stay 1 clk wide
    t1 = -1; t2 = -1; wide = 0; prev_fs = 0; prev_ls = 0;
    for (int k = 0; k < 6 * FT + 10 && t2 < 0; k++) begin
      pix_ce = (k % 3 == 0);
      @(negedge clk);
      if ((fs0 && prev_fs) || (ls0 && prev_ls)) wide++;
      prev_fs = fs0; prev_ls = ls0;
      if (fs0) begin
        if (t1 < 0) t1 = cyc;
        else        t2 = cyc;
      end
    end
    chk("div3_frame_period", t2 - t1, 3 * FT);
    chk("div3_strobe_width", wide, 0);
    pix_ce = 1'b1;

    // Short enable drop mid-frame is ignored
    wait_fs(2 * FT, t1);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("glitch_still_running", run0, 1);

    // Drop enable at y=3: frame completes to the last position, then IDLE
    for (int i = 0; i < 2 * FT && y0 != 3; i++) @(negedge clk);
    chk("reach_y3", y0, 3);
    enable = 1'b0;
    px = -1; py = -1;
    for (int i = 0; i < 2 * FT && run0; i++) begin
      px = x0; py = y0;
      @(negedge clk);
    end
    chk("stop_last_x", px, HT - 1);
    chk("stop_last_y", py, VT - 1);
    chk("stop_running", run0, 0);
    chk("stop_x", x0, 0);
    chk("stop_y", y0, 0);
    chk("stop_frame_start", fs0, 0);
    chk("stop_hsync", hs0, 1);
    chk("stop_vsync", vs0, 1);
    fcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (fs0) fcount++;
    end
    chk("idle_no_frame_start", fcount, 0);

    // Re-enable restarts at (0,0)
    enable = 1'b1;
    @(negedge clk);
    chk("restart_running", run0, 1);
    chk("restart_frame_start", fs0, 1);
    chk("restart_xy", {x0, y0}, 0);
    fc_before = fc0;
    repeat (5 * FT) @(negedge clk);
    chk("five_frames_fs", fs0, 1);
`ifdef VGA_FRAME_CNT_EN
    chk("frame_cnt_5_frames", fc0, (fc_before + 5) % (1 << FCW));
`endif

    // Asynchronous reset mid-line: outputs return immediately
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_x", x0, 0);
    chk("async_y", y0, 0);
    chk("async_running", run0, 0);
    chk("async_hsync_lo_pol", hs0, 1);
    chk("async_hsync_hi_pol", hs1, 0);
    chk("async_video_on", vo0, 0);
    chk("async_line_start", ls0, 0);
`ifdef VGA_FRAME_CNT_EN
    chk("async_frame_cnt", fc0, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_running", run0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
